// File: rtl/hpm_window_scheduler.sv
// Windows two free-running HPM counters, hands per-window deltas to the attack detector, logs its verdicts.
// Latency: det_end_i to alert_valid_o/irq_o is 1 cycle; a detector that never ends is abandoned after TIMEOUT WAIT cycles.
module hpm_window_scheduler #(
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int IRQ_THRESH = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIN_W-1:0] window_len_i,
    input  logic [1:0][31:0] hpm_i,
    output logic [1:0][31:0] det_hpm_o,
    output logic             det_enable_o,
    input  logic             det_end_i,
    input  logic [1:0]       det_alert_i,
    output logic [1:0]       alert_o,
    output logic             alert_valid_o,
    output logic             irq_o,
    output logic [CNT_W-1:0] attack_cnt_o,
    output logic             timeout_err_o,
    output logic             busy_o
);

    localparam int CW = $clog2(IRQ_THRESH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_SNAP,
        S_REQ,
        S_WAIT,
        S_LOG
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIN_W-1:0] win_len_eff;
    logic [WIN_W-1:0] win_cnt;
    logic [TW-1:0]    wait_cnt;
    logic [CW-1:0]    consec;
    logic [1:0][31:0] baseline;
    logic             log_now;
    logic             timeout_now;
    logic             is_attack;

    assign win_len_eff = (window_len_i < WIN_W'(2)) ? WIN_W'(2) : window_len_i;
    assign log_now     = (state == S_WAIT) && det_end_i;
    assign timeout_now = (state == S_WAIT) && !det_end_i && (wait_cnt == TW'(TIMEOUT - 1));
    assign is_attack   = (det_alert_i != 2'b00);

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en_i) state_nxt = S_COUNT;
            // COUNT always lasts at least one cycle; the counter sits at 2 one cycle before SNAP is due
            S_COUNT: begin
                if (!en_i) begin
                    state_nxt = S_IDLE;
                end else if (win_cnt <= WIN_W'(2)) begin
                    state_nxt = S_SNAP;
                end
            end
            S_SNAP:  state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (det_end_i) begin
                    state_nxt = S_LOG;
                end else if (timeout_now) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOG:   state_nxt = en_i ? S_COUNT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        det_enable_o  = 1'b0;
        alert_valid_o = 1'b0;
        busy_o        = 1'b1;
        case (state)
            S_IDLE:  busy_o        = 1'b0;
            S_REQ:   det_enable_o  = 1'b1;
            S_LOG:   alert_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            win_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (en_i) begin
                win_cnt <= win_len_eff;
            end
        end else if (state == S_SNAP) begin
            win_cnt <= win_len_eff;
        end else if (win_cnt != '0) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            wait_cnt <= '0;
        end else if (state == S_REQ) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Deltas are taken modulo 2^32 so a counter wrap inside the window still yields the event count
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            baseline  <= '0;
            det_hpm_o <= '0;
        end else if ((state == S_IDLE) && en_i) begin
            baseline <= hpm_i;
        end else if (state == S_SNAP) begin
            for (int k = 0; k < 2; k++) begin
                det_hpm_o[k] <= hpm_i[k] - baseline[k];
            end
            baseline <= hpm_i;
        end
    end

    // Logging is registered on the det_end_i cycle so alert, counts and irq all appear during LOG
    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            alert_o       <= 2'b00;
            irq_o         <= 1'b0;
            attack_cnt_o  <= '0;
            timeout_err_o <= 1'b0;
            consec        <= '0;
        end else begin
            if (log_now) begin
                alert_o <= det_alert_i;
            end
            if (clr_i) begin
                irq_o         <= 1'b0;
                attack_cnt_o  <= '0;
                timeout_err_o <= 1'b0;
                consec        <= '0;
            end else begin
                if (timeout_now) begin
                    timeout_err_o <= 1'b1;
                end
                if (log_now) begin
                    if (is_attack) begin
                        if (attack_cnt_o != '1) begin
                            attack_cnt_o <= attack_cnt_o + 1'b1;
                        end
                        if (int'(consec) < IRQ_THRESH) begin
                            consec <= consec + 1'b1;
                        end
                        if (int'(consec) + 1 >= IRQ_THRESH) begin
                            irq_o <= 1'b1;
                        end
                    end else begin
                        consec <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hpm_window_scheduler.sv
// Directed-plus-random bench for hpm_window_scheduler with a transaction-level reference model.
module tb_hpm_window_scheduler;

    localparam int WIN_W      = 16;
    localparam int CNT_W      = 16;
    localparam int IRQ_THRESH = 3;
    localparam int TIMEOUT    = 16;

    logic             clk_h;
    logic             rst_h;
    logic             en_i;
    logic             clr_i;
    logic [WIN_W-1:0] window_len_i;
    logic [1:0][31:0] hpm_i;
    logic [1:0][31:0] det_hpm_o;
    logic             det_enable_o;
    logic             det_end_i;
    logic [1:0]       det_alert_i;
    logic [1:0]       alert_o;
    logic             alert_valid_o;
    logic             irq_o;
    logic [CNT_W-1:0] attack_cnt_o;
    logic             timeout_err_o;
    logic             busy_o;

    hpm_window_scheduler #(
        .WIN_W      (WIN_W),
        .CNT_W      (CNT_W),
        .IRQ_THRESH (IRQ_THRESH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_h         (clk_h),
        .rst_h         (rst_h),
        .en_i          (en_i),
        .clr_i         (clr_i),
        .window_len_i  (window_len_i),
        .hpm_i         (hpm_i),
        .det_hpm_o     (det_hpm_o),
        .det_enable_o  (det_enable_o),
        .det_end_i     (det_end_i),
        .det_alert_i   (det_alert_i),
        .alert_o       (alert_o),
        .alert_valid_o (alert_valid_o),
        .irq_o         (irq_o),
        .attack_cnt_o  (attack_cnt_o),
        .timeout_err_o (timeout_err_o),
        .busy_o        (busy_o)
    );

    initial begin
        clk_h = 1'b0;
        forever #5 clk_h = ~clk_h;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          cyc;
    logic [31:0] hist0[$];
    logic [31:0] hist1[$];
    bit          rand_inc;
    logic [31:0] inc0;
    logic [31:0] inc1;
    int          base_cyc;
    int          exp_snap;
    int          leff;
    int          e_cyc;
    logic [31:0] last_d0;
    logic [31:0] last_d1;
    int          m_attack;
    int          m_consec;
    bit          m_irq;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: afterwards we are inside cycle 'cyc'; hist holds hpm_i as seen during each cycle
    task automatic tick();
        @(posedge clk_h);
        #1;
        cyc++;
        if (rand_inc) begin
            hpm_i[0] = hpm_i[0] + $urandom_range(0, 1000);
            hpm_i[1] = hpm_i[1] + $urandom_range(0, 1000);
        end else begin
            hpm_i[0] = hpm_i[0] + inc0;
            hpm_i[1] = hpm_i[1] + inc1;
        end
        hist0.push_back(hpm_i[0]);
        hist1.push_back(hpm_i[1]);
    endtask

    task automatic check_rst_vals(input string p);
        check({p, "_det_hpm"}, det_hpm_o, 64'd0);
        check({p, "_det_enable"}, det_enable_o, 0);
        check({p, "_alert"}, alert_o, 0);
        check({p, "_alert_valid"}, alert_valid_o, 0);
        check({p, "_irq"}, irq_o, 0);
        check({p, "_attack_cnt"}, attack_cnt_o, 0);
        check({p, "_timeout_err"}, timeout_err_o, 0);
        check({p, "_busy"}, busy_o, 0);
    endtask

    task automatic model_reset();
        m_attack = 0;
        m_consec = 0;
        m_irq    = 0;
    endtask

    // Begin a run in the current (IDLE) cycle: baseline is this cycle's counters
    task automatic start(input int len);
        check("start_idle", busy_o, 0);
        window_len_i = WIN_W'(len);
        leff         = (len < 2) ? 2 : len;
        en_i         = 1'b1;
        base_cyc     = cyc;
        exp_snap     = cyc + leff;
    endtask

    task automatic await_req();
        int n;
        int s;
        n = 0;
        while (det_enable_o !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check("req_seen", det_enable_o, 1);
        e_cyc = cyc;
        check("req_cycle", cyc, exp_snap + 1);
        s       = (exp_snap <= cyc) ? exp_snap : cyc;
        last_d0 = hist0[s] - hist0[base_cyc];
        last_d1 = hist1[s] - hist1[base_cyc];
        check("delta0", det_hpm_o[0], last_d0);
        check("delta1", det_hpm_o[1], last_d1);
    endtask

    // Detector answers 'd' cycles after the request; the window's verdict is checked in LOG
    task automatic do_window(input logic [1:0] cls, input int d, input bit last);
        await_req();
        repeat (d) tick();
        check("no_early_alert", alert_valid_o, 0);
        det_end_i   = 1'b1;
        det_alert_i = cls;
        tick();
        det_end_i   = 1'b0;
        det_alert_i = 2'($urandom);
        if (cls != 2'b00) begin
            if (m_attack < 65535) m_attack++;
            if (m_consec < IRQ_THRESH) m_consec++;
            if (m_consec == IRQ_THRESH) m_irq = 1;
        end else begin
            m_consec = 0;
        end
        check("log_valid", alert_valid_o, 1);
        check("log_class", alert_o, cls);
        check("log_attack_cnt", attack_cnt_o, m_attack);
        check("log_irq", irq_o, m_irq);
        base_cyc = exp_snap;
        exp_snap = exp_snap + imax(leff, 4 + d);
        if (last) begin
            en_i = 1'b0;
            tick();
            check("single_pulse", alert_valid_o, 0);
            check("back_to_idle", busy_o, 0);
        end
    endtask

    initial begin
        logic [1:0] esc[6];
        int         e_first;
        bit         seen;

        esc          = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b11};
        rst_h        = 1'b1;
        en_i         = 1'b0;
        clr_i        = 1'b0;
        window_len_i = '0;
        det_end_i    = 1'b0;
        det_alert_i  = 2'b00;
        hpm_i[0]     = 32'h0000_1234;
        hpm_i[1]     = 32'h0000_5678;
        rand_inc     = 1'b0;
        inc0         = 32'd1;
        inc1         = 32'd2;
        cyc          = 0;
        hist0.push_back(hpm_i[0]);
        hist1.push_back(hpm_i[1]);
        model_reset();

        // Reset values
        repeat (3) tick();
        rst_h = 1'b0;
        tick();
        check_rst_vals("reset");

        // Basic window: +1 / +2 per cycle, L=10, legit verdict
        start(10);
        do_window(2'b00, 2, 1'b1);
        check("basic_d0", det_hpm_o[0], 64'd10);
        check("basic_d1", det_hpm_o[1], 64'd20);
        check("basic_attack_cnt", attack_cnt_o, 0);

        // Counter wrap inside the window
        inc0     = 32'd1;
        inc1     = 32'd3;
        hpm_i[0] = 32'hFFFF_FFFC;
        hist0[cyc] = hpm_i[0];
        start(8);
        do_window(2'b00, 2, 1'b1);
        check("wrap_d0", det_hpm_o[0], 64'd8);

        // Escalation: 10 11 00 10 10 11 -> irq only on the 6th LOG
        rand_inc = 1'b1;
        start($urandom_range(2, 12));
        for (int i = 0; i < 6; i++) begin
            do_window(esc[i], $urandom_range(1, 4), i == 5);
        end
        check("esc_attack_cnt", attack_cnt_o, 5);
        check("esc_irq", irq_o, 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        model_reset();
        check("clr_irq", irq_o, 0);
        check("clr_attack_cnt", attack_cnt_o, 0);

        // Short window: length 0 behaves as 2, period 6 with a 2-cycle detector
        start(0);
        do_window(2'b00, 2, 1'b0);
        e_first = e_cyc;
        do_window(2'b10, 2, 1'b0);
        check("short_period_a", e_cyc - e_first, 6);
        e_first = e_cyc;
        do_window(2'b00, 2, 1'b1);
        check("short_period_b", e_cyc - e_first, 6);

        // Randomised runs against the model
        for (int r = 0; r < 3; r++) begin
            start($urandom_range(0, 14));
            for (int i = 0; i < 5; i++) begin
                do_window(2'($urandom), $urandom_range(1, 4), i == 4);
            end
        end

        // Ensure some non-reset state, then reset while in WAIT
        start(3);
        do_window(2'b11, 1, 1'b0);
        await_req();
        tick();
        check("rstw_in_wait", busy_o, 1);
        rst_h = 1'b1;
        en_i  = 1'b0;
        tick();
        check_rst_vals("rst_wait");
        rst_h = 1'b0;
        model_reset();
        tick();

        // Timeout: detector never ends
        start(5);
        await_req();
        en_i = 1'b0;
        seen = 1'b0;
        while (cyc < e_cyc + TIMEOUT) begin
            tick();
            if (alert_valid_o) seen = 1'b1;
        end
        check("to_not_yet", timeout_err_o, 0);
        check("to_still_wait", busy_o, 1);
        tick();
        if (alert_valid_o) seen = 1'b1;
        check("to_flag", timeout_err_o, 1);
        check("to_idle", busy_o, 0);
        check("to_no_alert", seen, 0);
        check("to_attack_cnt", attack_cnt_o, m_attack);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("to_clr", timeout_err_o, 0);

        // Abort mid-COUNT; stray det_end_i outside WAIT is ignored
        start(20);
        det_end_i   = 1'b1;
        det_alert_i = 2'b11;
        repeat (5) tick();
        det_end_i = 1'b0;
        check("abort_counting", busy_o, 1);
        en_i = 1'b0;
        tick();
        check("abort_idle", busy_o, 0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (det_enable_o || alert_valid_o) seen = 1'b1;
        end
        check("abort_no_req", seen, 0);
        check("abort_hpm_held", det_hpm_o, {last_d1, last_d0});
        check("abort_attack_cnt", attack_cnt_o, m_attack);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
